// File: rtl/id_stage_ctrl_if.sv
// Handshake and bundle signals between IF, the ID stage and EXU.
// master = surrounding pipeline (drives in_*, out_ready), slave = ID stage.
interface id_stage_ctrl_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_class;
    logic [2:0]      out_funct3;
    logic            out_word_op;
    logic            out_wen;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_imm, out_class, out_funct3, out_word_op, out_wen, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_imm, out_class, out_funct3, out_word_op, out_wen, out_illegal
    );
endinterface

// File: rtl/id_stage_ctrl.sv
// Registered RV decode stage with valid/ready handshake, load-use scoreboard and flush.
// Define ID_STAGE_PERF_EN to add the stall_cycles performance counter output.
module id_stage_ctrl #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NREG     = 32,
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           flush,
    id_stage_ctrl_if.slave bus
`ifdef ID_STAGE_PERF_EN
    ,
    output logic [31:0]    stall_cycles
`endif
);

    localparam int unsigned TW = 3;

    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_I      = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_JAL    = 3'd5;
    localparam logic [2:0] CLS_JALR   = 3'd6;
    localparam logic [2:0] CLS_U      = 3'd7;

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      dec_class;
    logic            dec_illegal;
    logic            dec_word;
    logic            dec_wen;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;

    logic            hazard_c;
    logic            in_ready_c;
    logic            accept;
    logic            arm;

    logic            out_valid_q,   out_valid_d;
    logic [XLEN-1:0] out_pc_q,      out_pc_d;
    logic [4:0]      out_rd_q,      out_rd_d;
    logic [4:0]      out_rs1_q,     out_rs1_d;
    logic [4:0]      out_rs2_q,     out_rs2_d;
    logic [XLEN-1:0] out_imm_q,     out_imm_d;
    logic [2:0]      out_class_q,   out_class_d;
    logic [2:0]      out_funct3_q,  out_funct3_d;
    logic            out_word_op_q, out_word_op_d;
    logic            out_wen_q,     out_wen_d;
    logic            out_illegal_q, out_illegal_d;

    logic [TW-1:0]   timer_q [NREG];
    logic [TW-1:0]   timer_d [NREG];

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];

    // Opcode classification; illegal opcodes produce an all-zero bundle with no sources.
    always_comb begin
        dec_class   = CLS_R;
        dec_illegal = 1'b0;
        dec_word    = 1'b0;
        imm32       = 32'd0;
        unique case (opcode)
            7'b0110011: dec_class = CLS_R;
            7'b0111011: begin
                if (XLEN == 32'd64) dec_word = 1'b1;
                else                dec_illegal = 1'b1;
            end
            7'b0010011: dec_class = CLS_I;
            7'b0011011: begin
                dec_class = CLS_I;
                if (XLEN == 32'd64) dec_word = 1'b1;
                else                dec_illegal = 1'b1;
            end
            7'b0000011: dec_class = CLS_LOAD;
            7'b0100011: dec_class = CLS_STORE;
            7'b1100011: dec_class = CLS_BRANCH;
            7'b1101111: dec_class = CLS_JAL;
            7'b1100111: dec_class = CLS_JALR;
            7'b0110111,
            7'b0010111: dec_class = CLS_U;
            default:    dec_illegal = 1'b1;
        endcase
        if (dec_illegal) dec_class = CLS_R;

        unique case (dec_class)
            CLS_I, CLS_LOAD, CLS_JALR:
                imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
            CLS_STORE:
                imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
            CLS_BRANCH:
                imm32 = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                         bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
            CLS_JAL:
                imm32 = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                         bus.in_instr[20], bus.in_instr[30:21], 1'b0};
            CLS_U:
                imm32 = {bus.in_instr[31:12], 12'd0};
            default:
                imm32 = 32'd0;
        endcase
        if (dec_illegal) imm32 = 32'd0;
    end

    assign dec_imm  = XLEN'($signed(imm32));
    assign dec_wen  = ~dec_illegal & (rd != 5'd0) &
                      (dec_class inside {CLS_R, CLS_I, CLS_LOAD, CLS_JAL, CLS_JALR, CLS_U});
    assign uses_rs1 = ~dec_illegal &
                      (dec_class inside {CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JALR});
    assign uses_rs2 = ~dec_illegal & (dec_class inside {CLS_R, CLS_STORE, CLS_BRANCH});

    // Stall on a running timer or on a load still sitting in the output register.
    always_comb begin
        hazard_c = 1'b0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (timer_q[i] != TW'(0)) begin
                if (uses_rs1 && (rs1 == 5'(i))) hazard_c = 1'b1;
                if (uses_rs2 && (rs2 == 5'(i))) hazard_c = 1'b1;
            end
        end
        if (out_valid_q && (out_class_q == CLS_LOAD) && (out_rd_q != 5'd0) &&
            ((uses_rs1 && (rs1 == out_rd_q)) || (uses_rs2 && (rs2 == out_rd_q))))
            hazard_c = 1'b1;
    end

    assign in_ready_c   = (~out_valid_q | bus.out_ready) & ~hazard_c & ~flush;
    assign bus.in_ready = in_ready_c;
    assign accept       = bus.in_valid & in_ready_c;
    assign arm          = out_valid_q & bus.out_ready & ~flush &
                          (out_class_q == CLS_LOAD) & (out_rd_q != 5'd0);

    // Issuing load reloads its rd timer; everything else counts down to zero.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            timer_d[i] = timer_q[i];
            if (arm && (out_rd_q == 5'(i)))
                timer_d[i] = TW'(LOAD_LAT);
            else if (timer_q[i] != TW'(0))
                timer_d[i] = timer_q[i] - TW'(1);
        end
    end

    always_comb begin
        out_valid_d   = accept | (out_valid_q & ~bus.out_ready & ~flush);
        out_pc_d      = out_pc_q;
        out_rd_d      = out_rd_q;
        out_rs1_d     = out_rs1_q;
        out_rs2_d     = out_rs2_q;
        out_imm_d     = out_imm_q;
        out_class_d   = out_class_q;
        out_funct3_d  = out_funct3_q;
        out_word_op_d = out_word_op_q;
        out_wen_d     = out_wen_q;
        out_illegal_d = out_illegal_q;
        if (accept) begin
            out_pc_d      = bus.in_pc;
            out_rd_d      = rd;
            out_rs1_d     = rs1;
            out_rs2_d     = rs2;
            out_imm_d     = dec_imm;
            out_class_d   = dec_class;
            out_funct3_d  = bus.in_instr[14:12];
            out_word_op_d = dec_word;
            out_wen_d     = dec_wen;
            out_illegal_d = dec_illegal;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_rd_q      <= '0;
            out_rs1_q     <= '0;
            out_rs2_q     <= '0;
            out_imm_q     <= '0;
            out_class_q   <= '0;
            out_funct3_q  <= '0;
            out_word_op_q <= 1'b0;
            out_wen_q     <= 1'b0;
            out_illegal_q <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) timer_q[i] <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_rd_q      <= out_rd_d;
            out_rs1_q     <= out_rs1_d;
            out_rs2_q     <= out_rs2_d;
            out_imm_q     <= out_imm_d;
            out_class_q   <= out_class_d;
            out_funct3_q  <= out_funct3_d;
            out_word_op_q <= out_word_op_d;
            out_wen_q     <= out_wen_d;
            out_illegal_q <= out_illegal_d;
            for (int unsigned i = 0; i < NREG; i++) timer_q[i] <= timer_d[i];
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_rs1     = out_rs1_q;
    assign bus.out_rs2     = out_rs2_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_class   = out_class_q;
    assign bus.out_funct3  = out_funct3_q;
    assign bus.out_word_op = out_word_op_q;
    assign bus.out_wen     = out_wen_q;
    assign bus.out_illegal = out_illegal_q;

`ifdef ID_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = stall_cnt_q + 32'(bus.in_valid & hazard_c & ~flush);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Self-checking bench for id_stage_ctrl: directed steps then random traffic against a reference model.
module tb_id_stage_ctrl;

    localparam int unsigned XL = 64;
    localparam int unsigned LL = 2;

    logic clk;
    logic rst;
    logic flush;
`ifdef ID_STAGE_PERF_EN
    logic [31:0] stall_cycles;
`endif

    id_stage_ctrl_if #(.XLEN(XL)) bus ();

    id_stage_ctrl #(.XLEN(XL), .NREG(32), .LOAD_LAT(LL)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .flush   (flush),
        .bus     (bus)
`ifdef ID_STAGE_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference state: held bundle plus, per register, the first cycle at which it is readable.
    longint      cyc;
    longint      avail [32];
    logic        m_ov;
    logic [63:0] m_pc;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [63:0] m_imm;
    logic [2:0]  m_cls, m_f3;
    logic        m_word, m_wen, m_ill;
    int          m_stall;

    logic [6:0]  ops [13];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] ins, output logic [2:0] cls,
                                       output logic ill, output logic word, output logic wen,
                                       output logic u1, output logic u2, output logic [63:0] imm);
        longint v;
        ill = 1'b0; word = 1'b0; cls = 3'd0; v = 0;
        case (ins[6:0])
            7'h33: cls = 3'd0;
            7'h3B: begin cls = 3'd0; word = 1'b1; end
            7'h13: cls = 3'd1;
            7'h1B: begin cls = 3'd1; word = 1'b1; end
            7'h03: cls = 3'd2;
            7'h23: cls = 3'd3;
            7'h63: cls = 3'd4;
            7'h6F: cls = 3'd5;
            7'h67: cls = 3'd6;
            7'h37, 7'h17: cls = 3'd7;
            default: ill = 1'b1;
        endcase
        if (!ill) begin
            case (cls)
                3'd1, 3'd2, 3'd6: v = longint'($signed(ins[31:20]));
                3'd3: v = longint'($signed({ins[31:25], ins[11:7]}));
                3'd4: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                3'd5: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                3'd7: v = longint'($signed({ins[31:12], 12'h000}));
                default: v = 0;
            endcase
        end
        imm = 64'(v);
        wen = !ill && (cls inside {3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd7}) && (ins[11:7] != 5'd0);
        u1  = !ill && (cls inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6});
        u2  = !ill && (cls inside {3'd0, 3'd3, 3'd4});
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 32; i++) avail[i] = 0;
        m_ov = 1'b0; m_pc = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0;
        m_cls = '0; m_f3 = '0; m_word = 1'b0; m_wen = 1'b0; m_ill = 1'b0; m_stall = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid",   bus.out_valid,   m_ov);
        chk("out_pc",      bus.out_pc,      m_pc);
        chk("out_rd",      bus.out_rd,      m_rd);
        chk("out_rs1",     bus.out_rs1,     m_rs1);
        chk("out_rs2",     bus.out_rs2,     m_rs2);
        chk("out_imm",     bus.out_imm,     m_imm);
        chk("out_class",   bus.out_class,   m_cls);
        chk("out_funct3",  bus.out_funct3,  m_f3);
        chk("out_word_op", bus.out_word_op, m_word);
        chk("out_wen",     bus.out_wen,     m_wen);
        chk("out_illegal", bus.out_illegal, m_ill);
`ifdef ID_STAGE_PERF_EN
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
    endtask

    // One clock: drive, check in_ready, advance the model, then check the registered outputs.
    task automatic do_cycle(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                            input logic ordy, input logic fl, output logic acc);
        logic [2:0]  cls;
        logic        ill, word, wen, u1, u2, haz, erdy;
        logic [63:0] imm;
        logic [4:0]  s1, s2;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        ref_decode(ins, cls, ill, word, wen, u1, u2, imm);
        s1 = ins[19:15];
        s2 = ins[24:20];
        haz = 1'b0;
        if (u1 && s1 != 5'd0 && cyc < avail[s1]) haz = 1'b1;
        if (u2 && s2 != 5'd0 && cyc < avail[s2]) haz = 1'b1;
        if (m_ov && m_cls == 3'd2 && m_rd != 5'd0 &&
            ((u1 && s1 == m_rd) || (u2 && s2 == m_rd))) haz = 1'b1;
        erdy = (!m_ov || ordy) && !haz && !fl;
        chk("in_ready", bus.in_ready, erdy);
        acc = v && erdy;
        if (m_ov && ordy && !fl && m_cls == 3'd2 && m_rd != 5'd0)
            avail[m_rd] = cyc + longint'(LL) + 1;
        if (v && haz && !fl) m_stall++;
        m_ov = acc || (m_ov && !ordy && !fl);
        if (acc) begin
            m_pc = pc; m_rd = ins[11:7]; m_rs1 = s1; m_rs2 = s2; m_imm = imm;
            m_cls = cls; m_f3 = ins[14:12]; m_word = word; m_wen = wen; m_ill = ill;
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    localparam logic [31:0] ADDI  = 32'h0070_0293;  // addi x5,x0,7
    localparam logic [31:0] LD6   = 32'h0000_B303;  // ld x6,0(x1)
    localparam logic [31:0] ADD7  = 32'h0023_03B3;  // add x7,x6,x2
    localparam logic [31:0] LD0   = 32'h0000_B003;  // ld x0,0(x1)
    localparam logic [31:0] ADD1  = 32'h0000_00B3;  // add x1,x0,x0
    localparam logic [31:0] ILL   = 32'h0000_007F;
    localparam logic [31:0] SW    = 32'hFE20_AE23;  // sw x2,-4(x1)

    logic        acc;
    int          n;
    logic [31:0] rins;
    logic        rv, rordy, rfl;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        ops = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h03, 7'h23, 7'h63,
                7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        reset_model();
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_outputs();
        chk("reset_in_ready", bus.in_ready, 1'b1);

        // addi decode, latency one cycle
        do_cycle(1'b1, ADDI, 64'h1000, 1'b1, 1'b0, acc);
        chk("addi_acc", acc, 1'b1);
        chk("addi_valid", bus.out_valid, 1'b1);
        chk("addi_class", bus.out_class, 3'd1);
        chk("addi_rd", bus.out_rd, 5'd5);
        chk("addi_imm", bus.out_imm, 64'd7);
        chk("addi_wen", bus.out_wen, 1'b1);
        chk("addi_ill", bus.out_illegal, 1'b0);

        // load-use: one held-load cycle plus LL timer cycles of stall
        do_cycle(1'b1, LD6, 64'h1004, 1'b1, 1'b0, acc);
        chk("ld_acc", acc, 1'b1);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 12) begin
            do_cycle(1'b1, ADD7, 64'h1008, 1'b1, 1'b0, acc);
            n++;
        end
        chk("loaduse_tries", 64'(n), 64'(LL + 2));

        // hold for four cycles, then release
        do_cycle(1'b1, ADDI, 64'h100C, 1'b0, 1'b0, acc);
        for (int i = 0; i < 4; i++) do_cycle(1'b1, ADD1, 64'h1010, 1'b0, 1'b0, acc);
        chk("hold_acc", acc, 1'b0);
        do_cycle(1'b1, ADD1, 64'h1010, 1'b1, 1'b0, acc);
        chk("release_acc", acc, 1'b1);

        // flush kills a held load and leaves no timer behind
        do_cycle(1'b1, LD6, 64'h1014, 1'b1, 1'b0, acc);
        do_cycle(1'b0, ADD7, 64'h0, 1'b1, 1'b1, acc);
        chk("flush_valid", bus.out_valid, 1'b0);
        do_cycle(1'b1, ADD7, 64'h1018, 1'b1, 1'b0, acc);
        chk("post_flush_acc", acc, 1'b1);

        // load to x0 never stalls
        do_cycle(1'b1, LD0, 64'h101C, 1'b1, 1'b0, acc);
        chk("ld0_wen", bus.out_wen, 1'b0);
        do_cycle(1'b1, ADD1, 64'h1020, 1'b1, 1'b0, acc);
        chk("ld0_add_acc", acc, 1'b1);

        // illegal opcode and store immediate
        do_cycle(1'b1, ILL, 64'h1024, 1'b1, 1'b0, acc);
        chk("ill_flag", bus.out_illegal, 1'b1);
        chk("ill_class", bus.out_class, 3'd0);
        do_cycle(1'b1, SW, 64'h1028, 1'b1, 1'b0, acc);
        chk("sw_class", bus.out_class, 3'd3);
        chk("sw_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);

        // reset in the middle of a load-use window
        do_cycle(1'b1, LD6, 64'h102C, 1'b1, 1'b0, acc);
        do_cycle(1'b0, ADD7, 64'h0, 1'b1, 1'b0, acc);
        rst = 1'b1;
        #1;
        reset_model();
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        cyc++;
        do_cycle(1'b1, ADD7, 64'h1030, 1'b1, 1'b0, acc);
        chk("post_reset_acc", acc, 1'b1);

        // random traffic over a small register set
        for (int k = 0; k < 400; k++) begin
            rins        = $urandom;
            rins[6:0]   = ops[$urandom_range(0, 12)];
            rins[11:7]  = 5'($urandom_range(0, 4));
            rins[19:15] = 5'($urandom_range(0, 4));
            rins[24:20] = 5'($urandom_range(0, 4));
            rv    = ($urandom_range(0, 3) != 0);
            rordy = ($urandom_range(0, 3) != 0);
            rfl   = ($urandom_range(0, 15) == 0);
            do_cycle(rv, rins, {$urandom, $urandom}, rordy, rfl, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
